event_barrier_ctrl: RTL and testbench

Parametrised successor to the per-argument barrier controllers placed between pipeline stages of a generated handler. It buffers PORT_COUNT single-beat argument channels in per-channel FIFOs of DEPTH entries and exports per-channel occupancy and barrier status. In ALIGN mode it releases one argument tuple only when every channel holds an entry, popping all channels in the same cycle. With ALIGN=0 it degenerates to independent per-channel queues.

---
 rtl/event_barrier_ctrl_if.sv | 33 +++
 rtl/event_barrier_ctrl.sv | 175 +++++++++++++++++
 tb/tb_event_barrier_ctrl.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/event_barrier_ctrl_if.sv
// event_barrier_ctrl_if: per-channel argument handshake bundle for the barrier controller.
// The s_* group carries arguments into the controller and the m_* group carries released
// arguments out. The controller connects through the slave modport and its environment
// connects through the master modport.
interface event_barrier_ctrl_if #(
    parameter int PORT_COUNT = 9,
    parameter int DATA_WIDTH = 32
);
    logic [PORT_COUNT*DATA_WIDTH-1:0] s_tdata;
    logic [PORT_COUNT-1:0]            s_tvalid;
    logic [PORT_COUNT-1:0]            s_tready;
    logic [PORT_COUNT*DATA_WIDTH-1:0] m_tdata;
    logic [PORT_COUNT-1:0]            m_tvalid;
    logic [PORT_COUNT-1:0]            m_tready;

    modport master (
        output s_tdata,
        output s_tvalid,
        input  s_tready,
        input  m_tdata,
        input  m_tvalid,
        output m_tready
    );

    modport slave (
        input  s_tdata,
        input  s_tvalid,
        output s_tready,
        output m_tdata,
        output m_tvalid,
        input  m_tready
    );
endinterface

// File: rtl/event_barrier_ctrl.sv
// event_barrier_ctrl: PORT_COUNT argument channels, each buffered in a DEPTH-entry FIFO.
// With ALIGN=1 a tuple is released only when every channel holds an entry, and all channels
// pop together. With ALIGN=0 every channel is an independent queue.
// Optional feature macro: EVENT_BARRIER_SKEW_MON_EN adds the sticky skew_err output, which
// flags one channel full while another is empty.
module event_barrier_ctrl #(
    parameter int PORT_COUNT = 9,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int ALIGN      = 1,
    localparam int CW        = $clog2(DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    event_barrier_ctrl_if.slave      bus,
    output logic [PORT_COUNT*CW-1:0] occupancy,
    output logic [PORT_COUNT-1:0]    barrier,
    output logic [15:0]              tuple_count
`ifdef EVENT_BARRIER_SKEW_MON_EN
    ,
    output logic                     skew_err
`endif
);

    localparam int            PW      = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic                  rst_done;
    logic [CW-1:0]         count      [PORT_COUNT];
    logic [CW-1:0]         count_next [PORT_COUNT];
    logic [PW-1:0]         wr_ptr     [PORT_COUNT];
    logic [PW-1:0]         rd_ptr     [PORT_COUNT];
    logic [DATA_WIDTH-1:0] mem        [PORT_COUNT][DEPTH];

    logic [PORT_COUNT-1:0] not_empty;
    logic [PORT_COUNT-1:0] full;
    logic [PORT_COUNT-1:0] push;
    logic [PORT_COUNT-1:0] pop;
    logic                  all_avail;
    logic                  release_tuple;
    logic                  tuple_inc;

    // Per-channel empty/full status taken straight from the registered counters.
    always_comb begin
        for (int i = 0; i < PORT_COUNT; i++) begin
            not_empty[i] = (count[i] != '0);
            full[i]      = (count[i] == DEPTH_C);
        end
    end

    // A tuple is available only when every channel holds at least one entry.
    assign all_avail     = &not_empty;
    assign release_tuple = all_avail & (&bus.m_tready);

    // Output valid is derived from registered counts only, so it never follows m_tready.
    assign bus.m_tvalid = (ALIGN != 0) ? {PORT_COUNT{all_avail}} : not_empty;

    // Aligned mode pops all channels together; independent mode pops per channel.
    assign pop = (ALIGN != 0) ? {PORT_COUNT{release_tuple}} : (not_empty & bus.m_tready);

    // The tuple counter tracks whole releases, or channel-0 pops in independent mode.
    assign tuple_inc = (ALIGN != 0) ? release_tuple : pop[0];

    // No full bypass: a full channel refuses a push even if it pops this cycle.
    assign bus.s_tready = {PORT_COUNT{rst_done}} & ~full;
    assign push         = bus.s_tvalid & bus.s_tready;

    // Next count per channel; simultaneous push and pop leaves it unchanged.
    always_comb begin
        for (int i = 0; i < PORT_COUNT; i++) begin
            count_next[i] = count[i];
            case ({push[i], pop[i]})
                2'b10:   count_next[i] = count[i] + CW'(1);
                2'b01:   count_next[i] = count[i] - CW'(1);
                default: count_next[i] = count[i];
            endcase
        end
    end

    // rst_done holds off s_tready until the first clock edge after reset release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rst_done <= 1'b0;
        end else begin
            rst_done <= 1'b1;
        end
    end

    // Counters, pointers, barrier flags and the tuple counter; reset discards buffered data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < PORT_COUNT; i++) begin
                count[i]  <= '0;
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
            end
            barrier     <= '0;
            tuple_count <= '0;
        end else begin
            for (int i = 0; i < PORT_COUNT; i++) begin
                count[i]   <= count_next[i];
                barrier[i] <= (count_next[i] != '0);
                if (push[i]) begin
                    wr_ptr[i] <= wr_ptr[i] + PW'(1);
                end
                if (pop[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + PW'(1);
                end
            end
            if (tuple_inc) begin
                tuple_count <= tuple_count + 16'd1;
            end
        end
    end

    // Entry storage has no reset; stale contents are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        for (int i = 0; i < PORT_COUNT; i++) begin
            if (push[i]) begin
                mem[i][wr_ptr[i]] <= bus.s_tdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Head entry of each channel is always presented; it is meaningless while empty.
    always_comb begin
        bus.m_tdata = '0;
        for (int i = 0; i < PORT_COUNT; i++) begin
            bus.m_tdata[i*DATA_WIDTH +: DATA_WIDTH] = mem[i][rd_ptr[i]];
        end
    end

    // Occupancy exports the raw per-channel counts.
    always_comb begin
        occupancy = '0;
        for (int i = 0; i < PORT_COUNT; i++) begin
            occupancy[i*CW +: CW] = count[i];
        end
    end

`ifdef EVENT_BARRIER_SKEW_MON_EN
    generate
        if (ALIGN != 0) begin : g_skew_mon
            logic any_full_next;
            logic any_empty_next;

            // Full and empty are exclusive per channel, so both flags set means two channels disagree.
            always_comb begin
                any_full_next  = 1'b0;
                any_empty_next = 1'b0;
                for (int i = 0; i < PORT_COUNT; i++) begin
                    if (count_next[i] == DEPTH_C) begin
                        any_full_next = 1'b1;
                    end
                    if (count_next[i] == '0) begin
                        any_empty_next = 1'b1;
                    end
                end
            end

            // Sticky skew flag, cleared only by reset.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    skew_err <= 1'b0;
                end else if (any_full_next && any_empty_next) begin
                    skew_err <= 1'b1;
                end
            end
        end else begin : g_skew_off
            assign skew_err = 1'b0;
        end
    endgenerate
`endif

endmodule

// File: tb/tb_event_barrier_ctrl.sv
// tb_event_barrier_ctrl: directed test of event_barrier_ctrl with PORT_COUNT=3, DATA_WIDTH=8,
// DEPTH=4. One instance runs in aligned mode and one in independent mode. Expected entries are
// queued when pushed, and monitors pop and compare them whenever a DUT hands data out.
module tb_event_barrier_ctrl;

    localparam int PC = 3;
    localparam int DW = 8;
    localparam int DP = 4;
    localparam int CW = $clog2(DP + 1);

    logic clk = 1'b0;
    logic rst = 1'b1;

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_a [PC][$];
    logic [7:0] exp_i [PC][$];

    event_barrier_ctrl_if #(.PORT_COUNT(PC), .DATA_WIDTH(DW)) bus_a ();
    event_barrier_ctrl_if #(.PORT_COUNT(PC), .DATA_WIDTH(DW)) bus_i ();

    logic [PC*CW-1:0] occ_a;
    logic [PC*CW-1:0] occ_i;
    logic [PC-1:0]    bar_a;
    logic [PC-1:0]    bar_i;
    logic [15:0]      tc_a;
    logic [15:0]      tc_i;
`ifdef EVENT_BARRIER_SKEW_MON_EN
    logic             skew_a;
    logic             skew_i;
`endif

    always #5 clk = ~clk;

    event_barrier_ctrl #(.PORT_COUNT(PC), .DATA_WIDTH(DW), .DEPTH(DP), .ALIGN(1)) dut_aligned (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus_a),
        .occupancy  (occ_a),
        .barrier    (bar_a),
        .tuple_count(tc_a)
`ifdef EVENT_BARRIER_SKEW_MON_EN
        ,
        .skew_err   (skew_a)
`endif
    );

    event_barrier_ctrl #(.PORT_COUNT(PC), .DATA_WIDTH(DW), .DEPTH(DP), .ALIGN(0)) dut_indep (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus_i),
        .occupancy  (occ_i),
        .barrier    (bar_i),
        .tuple_count(tc_i)
`ifdef EVENT_BARRIER_SKEW_MON_EN
        ,
        .skew_err   (skew_i)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("[TB] FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    // Drives one push cycle on the chosen instance; every valid channel is expected to accept.
    task automatic applyStimulus(input bit to_indep, input logic [2:0] valid,
                                 input logic [23:0] data, input logic [2:0] ready);
        if (!to_indep) begin
            bus_a.s_tvalid = valid;
            bus_a.s_tdata  = data;
            bus_a.m_tready = ready;
        end else begin
            bus_i.s_tvalid = valid;
            bus_i.s_tdata  = data;
            bus_i.m_tready = ready;
        end
        for (int i = 0; i < PC; i++) begin
            if (valid[i]) begin
                if (!to_indep) exp_a[i].push_back(data[i*8 +: 8]);
                else           exp_i[i].push_back(data[i*8 +: 8]);
            end
        end
        tick();
        if (!to_indep) bus_a.s_tvalid = '0;
        else           bus_i.s_tvalid = '0;
    endtask

    // Aligned monitor: valids must be uniform, and a release pops one entry per channel.
    initial begin : monitor_aligned
        logic [7:0] got;
        logic [7:0] want;
        forever begin
            @(negedge clk);
            if (bus_a.m_tvalid != '0) begin
                checks++;
                if (bus_a.m_tvalid !== 3'b111) begin
                    failures++;
                    $display("[TB] FAIL aligned_valid_uniform got=%b want=111", bus_a.m_tvalid);
                end
            end
            if ((&bus_a.m_tvalid) && (&bus_a.m_tready)) begin
                for (int i = 0; i < PC; i++) begin
                    got = bus_a.m_tdata[i*8 +: 8];
                    checks++;
                    if (exp_a[i].size() == 0) begin
                        failures++;
                        $display("[TB] FAIL aligned_unexpected_ch%0d got=%h want=none", i, got);
                    end else begin
                        want = exp_a[i].pop_front();
                        if (got !== want) begin
                            failures++;
                            $display("[TB] FAIL aligned_data_ch%0d got=%h want=%h", i, got, want);
                        end
                    end
                end
            end
        end
    end

    // Independent monitor: each channel handshake pops that channel's expectation.
    initial begin : monitor_indep
        logic [7:0] got;
        logic [7:0] want;
        forever begin
            @(negedge clk);
            for (int i = 0; i < PC; i++) begin
                if (bus_i.m_tvalid[i] && bus_i.m_tready[i]) begin
                    got = bus_i.m_tdata[i*8 +: 8];
                    checks++;
                    if (exp_i[i].size() == 0) begin
                        failures++;
                        $display("[TB] FAIL indep_unexpected_ch%0d got=%h want=none", i, got);
                    end else begin
                        want = exp_i[i].pop_front();
                        if (got !== want) begin
                            failures++;
                            $display("[TB] FAIL indep_data_ch%0d got=%h want=%h", i, got, want);
                        end
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        logic [2:0] mask;
        logic [7:0] d0;
        bus_a.s_tvalid = '0;
        bus_a.s_tdata  = '0;
        bus_a.m_tready = '0;
        bus_i.s_tvalid = '0;
        bus_i.s_tdata  = '0;
        bus_i.m_tready = '0;

        // Reset state
        #1 rst = 1'b0;
        #2;
        checkOutput("reset_s_tready", 32'(bus_a.s_tready), 32'h0);
        checkOutput("reset_m_tvalid", 32'(bus_a.m_tvalid), 32'h0);
        checkOutput("reset_occupancy", 32'(occ_a), 32'h0);
        checkOutput("reset_barrier", 32'(bar_a), 32'h0);
        checkOutput("reset_tuple_count", 32'(tc_a), 32'h0);
        tick();
        tick();
        rst = 1'b1;
        checkOutput("s_tready_before_rst_done", 32'(bus_a.s_tready), 32'h0);
        tick();
        checkOutput("s_tready_after_rst_done", 32'(bus_a.s_tready), 32'h7);

        // Aligned release
        applyStimulus(1'b0, 3'b011, {8'h00, 8'h22, 8'h11}, 3'b111);
        checkOutput("partial_tuple_m_tvalid", 32'(bus_a.m_tvalid), 32'h0);
        checkOutput("partial_tuple_barrier", 32'(bar_a), 32'h3);
        checkOutput("partial_tuple_occupancy", 32'(occ_a), 32'h009);
        applyStimulus(1'b0, 3'b100, {8'h33, 8'h00, 8'h00}, 3'b111);
        checkOutput("full_tuple_m_tvalid", 32'(bus_a.m_tvalid), 32'h7);
        checkOutput("full_tuple_m_tdata", 32'(bus_a.m_tdata), 32'h332211);
        tick();
        checkOutput("release_tuple_count", 32'(tc_a), 32'h1);
        checkOutput("release_occupancy", 32'(occ_a), 32'h0);

        // Partial ready holds the tuple
        applyStimulus(1'b0, 3'b111, {8'h03, 8'h02, 8'h01}, 3'b101);
        tick();
        tick();
        tick();
        checkOutput("partial_ready_occupancy", 32'(occ_a), 32'h049);
        checkOutput("partial_ready_tuple_count", 32'(tc_a), 32'h1);
        bus_a.m_tready = 3'b111;
        tick();
        checkOutput("ready_all_tuple_count", 32'(tc_a), 32'h2);
        checkOutput("ready_all_occupancy", 32'(occ_a), 32'h0);

        // Fill channel 0 and hold off the fifth entry
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b0, 3'b001, {16'h0000, 8'(8'hA0 + k)}, 3'b111);
        end
        checkOutput("ch0_full_occupancy", 32'(occ_a), 32'h004);
        checkOutput("ch0_full_s_tready", 32'(bus_a.s_tready), 32'h6);
        bus_a.s_tvalid = 3'b001;
        bus_a.s_tdata  = {16'h0000, 8'hA4};
        tick();
        bus_a.s_tvalid = '0;
        checkOutput("ch0_holdoff_occupancy", 32'(occ_a), 32'h004);
        checkOutput("ch0_holdoff_s_tready", 32'(bus_a.s_tready), 32'h6);
`ifdef EVENT_BARRIER_SKEW_MON_EN
        checkOutput("skew_err_aligned", 32'(skew_a), 32'h1);
        checkOutput("skew_err_indep_tied", 32'(skew_i), 32'h0);
`endif

        // Six tuples through channel 0 pointer wrap
        for (int k = 0; k < 6; k++) begin
            mask = (k == 2 || k == 3) ? 3'b111 : 3'b110;
            d0   = (k == 2) ? 8'hA4 : ((k == 3) ? 8'hA5 : 8'h00);
            applyStimulus(1'b0, mask, {8'(8'hC0 + k), 8'(8'hB0 + k), d0}, 3'b111);
        end
        tick();
        checkOutput("wrap_tuple_count", 32'(tc_a), 32'h8);
        checkOutput("wrap_occupancy", 32'(occ_a), 32'h0);

        // Independent mode
        applyStimulus(1'b1, 3'b010, {8'h00, 8'h5A, 8'h00}, 3'b111);
        checkOutput("indep_m_tvalid", 32'(bus_i.m_tvalid), 32'h2);
        tick();
        checkOutput("indep_ch1_tuple_count", 32'(tc_i), 32'h0);
        checkOutput("indep_ch1_occupancy", 32'(occ_i), 32'h0);
        applyStimulus(1'b1, 3'b001, {8'h00, 8'h00, 8'h77}, 3'b111);
        checkOutput("indep_ch0_m_tvalid", 32'(bus_i.m_tvalid), 32'h1);
        tick();
        checkOutput("indep_ch0_tuple_count", 32'(tc_i), 32'h1);

        // Reset mid-operation
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 3'b111, {8'(8'hE0 + k), 8'(8'hD0 + k), 8'(8'hF0 + k)}, 3'b000);
        end
        checkOutput("pre_reset_occupancy", 32'(occ_a), 32'h0DB);
        checkOutput("pre_reset_m_tvalid", 32'(bus_a.m_tvalid), 32'h7);
        #2 rst = 1'b0;
        #1;
        checkOutput("midrst_occupancy", 32'(occ_a), 32'h0);
        checkOutput("midrst_barrier", 32'(bar_a), 32'h0);
        checkOutput("midrst_m_tvalid", 32'(bus_a.m_tvalid), 32'h0);
        checkOutput("midrst_s_tready", 32'(bus_a.s_tready), 32'h0);
        checkOutput("midrst_tuple_count", 32'(tc_a), 32'h0);
        for (int i = 0; i < PC; i++) begin
            exp_a[i].delete();
            exp_i[i].delete();
        end
        bus_a.m_tready = 3'b111;
        tick();
        rst = 1'b1;
        checkOutput("post_rst_s_tready_early", 32'(bus_a.s_tready), 32'h0);
        tick();
        checkOutput("post_rst_s_tready", 32'(bus_a.s_tready), 32'h7);
        checkOutput("post_rst_m_tvalid", 32'(bus_a.m_tvalid), 32'h0);
        tick();
        checkOutput("post_rst_m_tvalid_later", 32'(bus_a.m_tvalid), 32'h0);

        // Full-rate streaming
        applyStimulus(1'b0, 3'b111, {8'h80, 8'h40, 8'h00}, 3'b111);
        for (int k = 1; k <= 20; k++) begin
            applyStimulus(1'b0, 3'b111, {8'(8'h80 + k), 8'(8'h40 + k), 8'(k)}, 3'b111);
            checkOutput("stream_occupancy", 32'(occ_a), 32'h049);
        end
        checkOutput("stream_tuple_count", 32'(tc_a), 32'd20);
        tick();
        checkOutput("stream_drain_tuple_count", 32'(tc_a), 32'd21);
        checkOutput("stream_drain_occupancy", 32'(occ_a), 32'h0);

        // Every queued expectation must have been consumed
        tick();
        for (int i = 0; i < PC; i++) begin
            checkOutput($sformatf("drain_aligned_ch%0d", i), 32'(exp_a[i].size()), 32'h0);
            checkOutput($sformatf("drain_indep_ch%0d", i), 32'(exp_i[i].size()), 32'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
